// File: rtl/seq_det_pkg.sv
// Shared encodings for the sequence-detector run controller:
// FSM state codes and end-of-run status codes.
package seq_det_pkg;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] ARM  = 2'b01;
  localparam logic [1:0] SCAN = 2'b10;
  localparam logic [1:0] DONE = 2'b11;

  localparam logic [1:0] ST_NONE    = 2'b00;
  localparam logic [1:0] ST_TARGET  = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_ABORT   = 2'b11;

endpackage

// File: rtl/seq_det_core.sv
// Mealy detection core: bit history, fill counter and combinational
// pattern compare against the current valid input bit.
module seq_det_core #(
  parameter int PAT_W = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Clr,
  input  logic             En,
  input  logic             In,
  input  logic             In_Valid,
  input  logic [PAT_W-1:0] Pattern,
  input  logic             Overlap,
  output logic             Match
);

  localparam int FILL_W = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  logic [PAT_W-2:0]  hist;
  logic [FILL_W-1:0] fill;
  logic [PAT_W-1:0]  cand;
  logic              step;

  assign cand  = {hist, In};
  assign step  = En & In_Valid;
  assign Match = step & (fill == FILL_MAX) & (cand == Pattern);

  // Non-overlapping mode restarts the fill so the next match needs a
  // full fresh pattern; history itself is kept either way.
  always_ff @(posedge Clk) begin
    if (Rst || Clr) begin
      hist <= '0;
      fill <= '0;
    end else if (step) begin
      hist <= cand[PAT_W-2:0];
      if (Match && !Overlap)
        fill <= '0;
      else if (fill != FILL_MAX)
        fill <= fill + FILL_W'(1);
    end
  end

endmodule

// File: rtl/seq_det_scan_ctrl.sv
// Run controller: latches a run configuration, scans the serial stream
// through seq_det_core and reports the end cause with a Done/Ack handshake.
module seq_det_scan_ctrl
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int TO_W  = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             Abort,
  input  logic             Ack,
  input  logic [PAT_W-1:0] Pattern,
  input  logic             Overlap,
  input  logic [CNT_W-1:0] Target,
  input  logic [TO_W-1:0]  Timeout,
  input  logic             In,
  input  logic             In_Valid,
  output logic             Busy,
  output logic             Match,
  output logic [CNT_W-1:0] Match_Cnt,
  output logic             Done,
  output logic [1:0]       Status
);

  logic [1:0]       state;
  logic [PAT_W-1:0] pat_q;
  logic             ovl_q;
  logic [CNT_W-1:0] tgt_q;
  logic [TO_W-1:0]  to_q;
  logic [TO_W-1:0]  to_cnt;
  logic [CNT_W-1:0] match_cnt;
  logic [1:0]       status;
  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W-1:0] cnt_sat;
  logic             target_hit;
  logic             timeout_hit;

  seq_det_core #(.PAT_W(PAT_W)) u_core (
    .Clk      (Clk),
    .Rst      (Rst),
    .Clr      (state == ARM),
    .En       (state == SCAN),
    .In       (In),
    .In_Valid (In_Valid),
    .Pattern  (pat_q),
    .Overlap  (ovl_q),
    .Match    (Match)
  );

  // Target compare uses the unsaturated sum so an all-ones target still fires.
  assign cnt_inc     = {1'b0, match_cnt} + (CNT_W+1)'(1);
  assign cnt_sat     = (&match_cnt) ? match_cnt : cnt_inc[CNT_W-1:0];
  assign target_hit  = Match && (tgt_q != '0) && (cnt_inc == {1'b0, tgt_q});
  assign timeout_hit = (to_q != '0) && (to_cnt == to_q - TO_W'(1));

  assign Busy      = (state == ARM) || (state == SCAN);
  assign Done      = (state == DONE);
  assign Match_Cnt = match_cnt;
  assign Status    = status;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      pat_q     <= '0;
      ovl_q     <= 1'b0;
      tgt_q     <= '0;
      to_q      <= '0;
      to_cnt    <= '0;
      match_cnt <= '0;
      status    <= ST_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (Start)
            state <= ARM;
        end
        ARM: begin
          pat_q     <= Pattern;
          ovl_q     <= Overlap;
          tgt_q     <= Target;
          to_q      <= Timeout;
          to_cnt    <= '0;
          match_cnt <= '0;
          if (Abort) begin
            state  <= DONE;
            status <= ST_ABORT;
          end else begin
            state  <= SCAN;
            status <= ST_NONE;
          end
        end
        SCAN: begin
          to_cnt <= to_cnt + TO_W'(1);
          if (Match)
            match_cnt <= cnt_sat;
          // Exit causes in priority order: abort, target, timeout.
          if (Abort) begin
            state  <= DONE;
            status <= ST_ABORT;
          end else if (target_hit) begin
            state  <= DONE;
            status <= ST_TARGET;
          end else if (timeout_hit) begin
            state  <= DONE;
            status <= ST_TIMEOUT;
          end
        end
        DONE: begin
          if (Ack)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_det_scan_ctrl.sv
// Directed self-checking bench for seq_det_scan_ctrl with hand-computed
// expectations for each run scenario.
module tb_seq_det_scan_ctrl;

  logic       Clk = 1'b0;
  logic       Rst, Start, Abort, Ack, Overlap, In, In_Valid;
  logic [3:0] Pattern;
  logic [7:0] Target;
  logic [15:0] Timeout;
  logic       Busy, Match, Done;
  logic [7:0] Match_Cnt;
  logic [1:0] Status;

  int vectors    = 0;
  int miscompares = 0;

  seq_det_scan_ctrl #(.PAT_W(4), .CNT_W(8), .TO_W(16)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Start     (Start),
    .Abort     (Abort),
    .Ack       (Ack),
    .Pattern   (Pattern),
    .Overlap   (Overlap),
    .Target    (Target),
    .Timeout   (Timeout),
    .In        (In),
    .In_Valid  (In_Valid),
    .Busy      (Busy),
    .Match     (Match),
    .Match_Cnt (Match_Cnt),
    .Done      (Done),
    .Status    (Status)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Starts a run, leaves the DUT in its first SCAN cycle, then scrambles
  // the configuration inputs so that only latched values can be in effect.
  task automatic start_run(input logic [3:0] pat, input logic ovl,
                           input logic [7:0] tgt, input logic [15:0] to);
    Pattern = pat; Overlap = ovl; Target = tgt; Timeout = to;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    Pattern = ~pat; Overlap = ~ovl; Target = 8'd1; Timeout = 16'd3;
  endtask

  task automatic send_bit(input string name, input logic b, input logic v,
                          input logic exp_match);
    In = b; In_Valid = v;
    #1;
    vectors++;
    if (Match !== exp_match) begin
      miscompares++;
      $display("[TB] FAIL %s match got %b exp %b", name, Match, exp_match);
    end
    tick();
    In_Valid = 1'b0;
  endtask

  task automatic do_ack();
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1; Start = 0; Abort = 0; Ack = 0; In = 0; In_Valid = 0;
    Pattern = 0; Overlap = 0; Target = 0; Timeout = 0;
    tick(); tick();
    Rst = 1'b0;
    vectors++;
    if ({Busy, Done, Match, Match_Cnt, Status} !== 13'd0) begin
      miscompares++;
      $display("[TB] FAIL reset outputs got busy=%b done=%b match=%b cnt=%0d st=%b exp all 0",
               Busy, Done, Match, Match_Cnt, Status);
    end
  endtask

  task automatic test_timeout_nonoverlap();
    start_run(4'b1010, 1'b0, 8'd0, 16'd20);
    send_bit("t1_b1", 1, 1, 0); send_bit("t1_b2", 0, 1, 0);
    send_bit("t1_b3", 1, 1, 0); send_bit("t1_b4", 0, 1, 1);
    send_bit("t1_b5", 1, 1, 0); send_bit("t1_b6", 0, 1, 0);
    for (int i = 0; i < 13; i++) tick();
    vectors++;
    if (Busy !== 1'b1 || Done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL t1_scan20 got busy=%b done=%b exp busy=1 done=0", Busy, Done);
    end
    tick();
    vectors++;
    if (Done !== 1'b1 || Status !== 2'b10 || Match_Cnt !== 8'd1 || Busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL t1_done got done=%b st=%b cnt=%0d busy=%b exp done=1 st=10 cnt=1 busy=0",
               Done, Status, Match_Cnt, Busy);
    end
    do_ack();
    vectors++;
    if (Done !== 1'b0 || Status !== 2'b10 || Match_Cnt !== 8'd1) begin
      miscompares++;
      $display("[TB] FAIL t1_idle_hold got done=%b st=%b cnt=%0d exp done=0 st=10 cnt=1",
               Done, Status, Match_Cnt);
    end
  endtask

  task automatic test_timeout_overlap();
    start_run(4'b1010, 1'b1, 8'd0, 16'd20);
    send_bit("t2_b1", 1, 1, 0); send_bit("t2_b2", 0, 1, 0);
    send_bit("t2_b3", 1, 1, 0); send_bit("t2_b4", 0, 1, 1);
    send_bit("t2_b5", 1, 1, 0); send_bit("t2_b6", 0, 1, 1);
    for (int i = 0; i < 14; i++) tick();
    vectors++;
    if (Done !== 1'b1 || Status !== 2'b10 || Match_Cnt !== 8'd2) begin
      miscompares++;
      $display("[TB] FAIL t2_done got done=%b st=%b cnt=%0d exp done=1 st=10 cnt=2",
               Done, Status, Match_Cnt);
    end
    do_ack();
  endtask

  task automatic test_target();
    start_run(4'b1010, 1'b1, 8'd2, 16'd0);
    send_bit("t3_b1", 1, 1, 0); send_bit("t3_b2", 0, 1, 0);
    send_bit("t3_b3", 1, 1, 0); send_bit("t3_b4", 0, 1, 1);
    send_bit("t3_b5", 1, 1, 0); send_bit("t3_b6", 0, 1, 1);
    vectors++;
    if (Done !== 1'b1 || Status !== 2'b01 || Match_Cnt !== 8'd2) begin
      miscompares++;
      $display("[TB] FAIL t3_done got done=%b st=%b cnt=%0d exp done=1 st=01 cnt=2",
               Done, Status, Match_Cnt);
    end
    Start = 1'b1;
    tick(); tick();
    Start = 1'b0;
    vectors++;
    if (Done !== 1'b1 || Busy !== 1'b0 || Status !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL t3_hold got done=%b busy=%b st=%b exp done=1 busy=0 st=01",
               Done, Busy, Status);
    end
    do_ack();
    vectors++;
    if (Done !== 1'b0 || Busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL t3_ack got done=%b busy=%b exp done=0 busy=0", Done, Busy);
    end
  endtask

  task automatic test_invalid_gap();
    start_run(4'b1010, 1'b0, 8'd0, 16'd0);
    send_bit("t4_b1", 1, 1, 0); send_bit("t4_b2", 0, 1, 0);
    send_bit("t4_gap1", 1, 0, 0); send_bit("t4_gap2", 0, 0, 0);
    send_bit("t4_gap3", 1, 0, 0);
    send_bit("t4_b3", 1, 1, 0); send_bit("t4_b4", 0, 1, 1);
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    vectors++;
    if (Done !== 1'b1 || Status !== 2'b11 || Match_Cnt !== 8'd1) begin
      miscompares++;
      $display("[TB] FAIL t4_abort got done=%b st=%b cnt=%0d exp done=1 st=11 cnt=1",
               Done, Status, Match_Cnt);
    end
    do_ack();
  endtask

  task automatic test_abort_with_match();
    start_run(4'b1010, 1'b0, 8'd1, 16'd0);
    send_bit("t5_b1", 1, 1, 0); send_bit("t5_b2", 0, 1, 0);
    send_bit("t5_b3", 1, 1, 0);
    Abort = 1'b1;
    send_bit("t5_b4", 0, 1, 1);
    Abort = 1'b0;
    vectors++;
    if (Done !== 1'b1 || Status !== 2'b11 || Match_Cnt !== 8'd1) begin
      miscompares++;
      $display("[TB] FAIL t5_abort got done=%b st=%b cnt=%0d exp done=1 st=11 cnt=1",
               Done, Status, Match_Cnt);
    end
    do_ack();
  endtask

  task automatic test_abort_in_arm();
    Pattern = 4'b1010; Overlap = 0; Target = 0; Timeout = 0;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    vectors++;
    if (Done !== 1'b1 || Status !== 2'b11 || Match_Cnt !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL arm_abort got done=%b st=%b cnt=%0d exp done=1 st=11 cnt=0",
               Done, Status, Match_Cnt);
    end
    do_ack();
  endtask

  task automatic test_reset_mid_scan();
    start_run(4'b1111, 1'b1, 8'd0, 16'd0);
    send_bit("t6_b1", 1, 1, 0); send_bit("t6_b2", 1, 1, 0);
    send_bit("t6_b3", 1, 1, 0); send_bit("t6_b4", 1, 1, 1);
    send_bit("t6_b5", 1, 1, 1); send_bit("t6_b6", 1, 1, 1);
    vectors++;
    if (Match_Cnt !== 8'd3 || Busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL t6_pre got cnt=%0d busy=%b exp cnt=3 busy=1", Match_Cnt, Busy);
    end
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    vectors++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Match_Cnt !== 8'd0 || Status !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL t6_reset got busy=%b done=%b cnt=%0d st=%b exp 0 0 0 00",
               Busy, Done, Match_Cnt, Status);
    end
  endtask

  initial begin
    test_reset();
    test_timeout_nonoverlap();
    test_timeout_overlap();
    test_target();
    test_invalid_gap();
    test_abort_with_match();
    test_abort_in_arm();
    test_reset_mid_scan();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_det_scan_ctrl.md
Name: seq_det_scan_ctrl

Overview:
Run-controller for the team's Mealy sequence detectors. It latches a programmable pattern and run configuration, then arms an internal Mealy detection core. It counts detections on a serial bit stream and ends the run on target count, timeout or abort. Completion is reported with a Done/Ack handshake to the host sequencer. It sits between the host control registers and the serial input path.

Parameters:
PAT_W, 4, pattern length in bits (2..16); the pattern is matched MSB first.
CNT_W, 8, width of the match counter and the target count.
TO_W, 16, width of the timeout cycle count.

Ports:
Clk  input  1  system clock, rising edge.
Rst  input  1  synchronous reset, active-high; overrides all other inputs.
Start  input  1  run request; sampled only in IDLE.
Abort  input  1  terminates an active run (ARM or SCAN).
Ack  input  1  host acknowledge of Done; sampled only in DONE.
Pattern  input  PAT_W  pattern to detect; latched in ARM.
Overlap  input  1  1 = overlapping detection, 0 = non-overlapping; latched in ARM.
Target  input  CNT_W  number of matches that ends the run; 0 = no limit; latched in ARM.
Timeout  input  TO_W  maximum SCAN length in cycles; 0 = disabled; latched in ARM.
In  input  1  serial data bit.
In_Valid  input  1  qualifies In.
Busy  output  1  high in ARM and SCAN.
Match  output  1  Mealy output: high in the same cycle as the completing valid bit.
Match_Cnt  output  CNT_W  matches in the current or last run.
Done  output  1  high throughout DONE.
Status  output  2  end cause: 00 none, 01 target reached, 10 timeout, 11 aborted.

Behaviour:
- Reset values: state IDLE; Busy=0, Match=0, Match_Cnt=0, Done=0, Status=00; history and fill cleared.
- State IDLE:
  - Start=1 -> ARM.
  - Match_Cnt and Status hold their last-run values.
- State ARM (exactly 1 cycle):
  - Latch Pattern, Overlap, Target and Timeout.
  - Clear Match_Cnt, Status, history, fill and the timeout counter.
  - Abort=1 -> DONE with Status 11; otherwise -> SCAN.
- Detection in SCAN, only on cycles with In_Valid=1:
  - The candidate word is {hist[PAT_W-2:0], In}.
  - Match = In_Valid & (fill >= PAT_W-1) & (candidate == latched pattern).
  - On a valid cycle, the history shifts in In and fill increments, saturating at PAT_W-1.
  - On a match with Overlap=0, fill clears to 0 and history is kept.
  - On a match with Overlap=1, fill is not cleared.
  - With In_Valid=0, history is unchanged and Match=0.
  - Match is 0 outside SCAN.
- Match_Cnt increments on every Match and saturates at all ones.
- Timeout counter increments on every SCAN cycle, valid or not.
- SCAN exit causes, in priority order when several occur in the same cycle:
  - Abort -> DONE, Status 11.
  - Match with Target!=0 and Match_Cnt+1 == Target -> DONE, Status 01.
  - Timeout!=0 and timeout counter == Timeout-1 -> DONE, Status 10. SCAN therefore lasts at most Timeout cycles.
- On any SCAN exit, the exiting cycle's Match is still counted.
- State DONE:
  - Done=1; Status and Match_Cnt are held.
  - Ack=1 -> IDLE, with Done low the next cycle.
  - Start is ignored in DONE.
- Start outside IDLE and Abort in IDLE or DONE are ignored.
- Configuration input changes outside ARM have no effect.
- Rst in any state returns to the reset values on the next edge. An interrupted run leaves no Status.
- With Target=0 and Timeout=0, the run ends only on Abort.

Decomposition:
- Package seq_det_pkg holds:
  - the state encoding IDLE=2'b00, ARM=2'b01, SCAN=2'b10, DONE=2'b11;
  - the Status constants ST_NONE, ST_TARGET, ST_TIMEOUT, ST_ABORT.
- One sub-module, seq_det_core:
  - contains the history shift register, fill counter and Mealy compare;
  - ports: Clk, Rst, Clr, En, In, In_Valid, Pattern, Overlap, Match.
- The controller FSM, match counter and timeout counter remain in seq_det_scan_ctrl.

Test Plan:
1. Pattern=1010, Overlap=0, Target=0, Timeout=20; valid bits 1,0,1,0,1,0 -> Match high only on the 4th bit; Match_Cnt=1; Done with Status 10 after the 20th SCAN cycle.
2. As test 1 with Overlap=1 -> Match high on the 4th and 6th bits; Match_Cnt=2; Status 10.
3. Overlap=1, Target=2; same stream -> Match_Cnt=2 on the edge after the 6th bit, where DONE is entered with Status 01; Done holds until Ack, then IDLE; Busy=0.
4. Pattern=1010; valid bits 1,0 then In_Valid=0 for 3 cycles, then bits 1,0 -> a single match on the final bit; no match during the invalid gap.
5. Abort in the same cycle as a target-completing match -> Status 11; Match_Cnt includes that match.
6. Rst asserted mid-SCAN with Match_Cnt=3 -> the next cycle shows IDLE, Match_Cnt=0, Status 00, Done=0; Start pulsed in DONE is ignored.
